// File: rtl/bus_arbiter_pkg.sv
// Shared constants, state type and small helpers for the three-master bus arbiter.
package bus_arbiter_pkg;

  localparam int ADDR_BUS_WIDTH = 32;
  localparam int DATA_BUS_WIDTH = 32;
  localparam int HOLD_CNT_WIDTH = 8;

  localparam logic [1:0] MASTER_LSU = 2'd0;
  localparam logic [1:0] MASTER_IF  = 2'd1;
  localparam logic [1:0] MASTER_DBG = 2'd2;
  localparam logic [1:0] GNT_NONE   = 2'd3;

  localparam logic [DATA_BUS_WIDTH-1:0] ZERO_WORD = '0;
  localparam logic                      INVALID   = 1'b0;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } arb_state_e;

  // One-hot mask for a master ID; GNT_NONE masks nothing.
  function automatic logic [2:0] id_mask(input logic [1:0] id);
    case (id)
      MASTER_LSU: return 3'b001;
      MASTER_IF:  return 3'b010;
      MASTER_DBG: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] rr_next(input logic [1:0] id);
    return (id == MASTER_DBG) ? MASTER_LSU : id + 2'd1;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side and decoder-side signals of the arbiter, bundled for port hookup.
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic [ADDR_BUS_WIDTH-1:0] m0_addr_i, m1_addr_i, m2_addr_i;
  logic [DATA_BUS_WIDTH-1:0] m0_data_i, m1_data_i, m2_data_i;
  logic                      m0_we_i, m1_we_i, m2_we_i;
  logic                      m0_rd_i, m1_rd_i, m2_rd_i;
  logic [DATA_BUS_WIDTH-1:0] m0_data_o, m1_data_o, m2_data_o;
  logic                      m0_gnt_o, m1_gnt_o, m2_gnt_o;
  logic                      m0_stall_o, m1_stall_o, m2_stall_o;
  logic [ADDR_BUS_WIDTH-1:0] s_addr_o;
  logic [DATA_BUS_WIDTH-1:0] s_data_o;
  logic                      s_we_o, s_rd_o;
  logic [DATA_BUS_WIDTH-1:0] s_data_i;
  logic [1:0]                gnt_id_o;
  logic                      busy_o;

  // Arbiter side
  modport slave (
    input  m0_addr_i, m1_addr_i, m2_addr_i,
    input  m0_data_i, m1_data_i, m2_data_i,
    input  m0_we_i, m1_we_i, m2_we_i,
    input  m0_rd_i, m1_rd_i, m2_rd_i,
    output m0_data_o, m1_data_o, m2_data_o,
    output m0_gnt_o, m1_gnt_o, m2_gnt_o,
    output m0_stall_o, m1_stall_o, m2_stall_o,
    output s_addr_o, s_data_o, s_we_o, s_rd_o,
    input  s_data_i,
    output gnt_id_o, busy_o
  );

  // Requester / decoder side
  modport master (
    output m0_addr_i, m1_addr_i, m2_addr_i,
    output m0_data_i, m1_data_i, m2_data_i,
    output m0_we_i, m1_we_i, m2_we_i,
    output m0_rd_i, m1_rd_i, m2_rd_i,
    input  m0_data_o, m1_data_o, m2_data_o,
    input  m0_gnt_o, m1_gnt_o, m2_gnt_o,
    input  m0_stall_o, m1_stall_o, m2_stall_o,
    input  s_addr_o, s_data_o, s_we_o, s_rd_o,
    output s_data_i,
    input  gnt_id_o, busy_o
  );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin pick: first requester at or above ptr (with wrap),
// skipping the excluded ID.
module rr_picker
  import bus_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  input  logic [1:0] excl,
  output logic [1:0] win,
  output logic       valid
);

  logic [2:0] cand;

  assign cand  = req & ~id_mask(excl);
  assign valid = |cand;

  always_comb begin
    win = GNT_NONE;
    case (ptr)
      2'd1: begin
        if      (cand[1]) win = MASTER_IF;
        else if (cand[2]) win = MASTER_DBG;
        else if (cand[0]) win = MASTER_LSU;
      end
      2'd2: begin
        if      (cand[2]) win = MASTER_DBG;
        else if (cand[0]) win = MASTER_LSU;
        else if (cand[1]) win = MASTER_IF;
      end
      default: begin
        if      (cand[0]) win = MASTER_LSU;
        else if (cand[1]) win = MASTER_IF;
        else if (cand[2]) win = MASTER_DBG;
      end
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter with per-grant hold limit sharing the decoder port among
// LSU (m0), instruction fetch (m1) and debug (m2).
//   state    | meaning
//   ST_IDLE  | no owner, shared port driven to idle values
//   ST_GRANT | gnt_q owns the port, hold_cnt counts cycles of this grant
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8
) (
  input logic      clk,
  input logic      rst_n,
  bus_arbiter_if.slave bus
);

  localparam logic [HOLD_CNT_WIDTH-1:0] HOLD_LAST = HOLD_CNT_WIDTH'(HOLD_MAX - 1);

  arb_state_e                state_q, state_d;
  logic [1:0]                gnt_q, gnt_d;
  logic [1:0]                rr_ptr, rr_d;
  logic [HOLD_CNT_WIDTH-1:0] hold_cnt, hold_d;

  logic [2:0] req;
  logic [1:0] excl, pick_id;
  logic       pick_valid, owner_req, take, busy;
  logic       gnt0, gnt1, gnt2;

  assign req = {bus.m2_we_i | bus.m2_rd_i,
                bus.m1_we_i | bus.m1_rd_i,
                bus.m0_we_i | bus.m0_rd_i};

  // While granted the owner is excluded, so a pick always means a handover target.
  assign excl      = (state_q == ST_GRANT) ? gnt_q : GNT_NONE;
  assign owner_req = |(req & id_mask(gnt_q));

  rr_picker u_picker (
    .req  (req),
    .ptr  (rr_ptr),
    .excl (excl),
    .win  (pick_id),
    .valid(pick_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= GNT_NONE;
      rr_ptr   <= MASTER_LSU;
      hold_cnt <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr   <= rr_d;
      hold_cnt <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_ptr;
    hold_d  = hold_cnt;
    take    = 1'b0;
    case (state_q)
      ST_IDLE: take = pick_valid;
      ST_GRANT: begin
        if (!owner_req) begin
          take = pick_valid;
          if (!pick_valid) begin
            state_d = ST_IDLE;
            gnt_d   = GNT_NONE;
            hold_d  = '0;
          end
        end else if (hold_cnt == HOLD_LAST) begin
          take = pick_valid;
        end else begin
          hold_d = hold_cnt + HOLD_CNT_WIDTH'(1);
        end
      end
    endcase
    if (take) begin
      state_d = ST_GRANT;
      gnt_d   = pick_id;
      rr_d    = rr_next(pick_id);
      hold_d  = '0;
    end
  end

  assign busy = (state_q == ST_GRANT);
  assign gnt0 = busy & (gnt_q == MASTER_LSU);
  assign gnt1 = busy & (gnt_q == MASTER_IF);
  assign gnt2 = busy & (gnt_q == MASTER_DBG);

  always_comb begin
    bus.s_addr_o = ZERO_WORD;
    bus.s_data_o = ZERO_WORD;
    bus.s_we_o   = INVALID;
    bus.s_rd_o   = INVALID;
    if (gnt0) begin
      bus.s_addr_o = bus.m0_addr_i;
      bus.s_data_o = bus.m0_data_i;
      bus.s_we_o   = bus.m0_we_i;
      bus.s_rd_o   = bus.m0_rd_i;
    end else if (gnt1) begin
      bus.s_addr_o = bus.m1_addr_i;
      bus.s_data_o = bus.m1_data_i;
      bus.s_we_o   = bus.m1_we_i;
      bus.s_rd_o   = bus.m1_rd_i;
    end else if (gnt2) begin
      bus.s_addr_o = bus.m2_addr_i;
      bus.s_data_o = bus.m2_data_i;
      bus.s_we_o   = bus.m2_we_i;
      bus.s_rd_o   = bus.m2_rd_i;
    end
  end

  assign bus.m0_gnt_o   = gnt0;
  assign bus.m1_gnt_o   = gnt1;
  assign bus.m2_gnt_o   = gnt2;
  assign bus.m0_stall_o = req[0] & ~gnt0;
  assign bus.m1_stall_o = req[1] & ~gnt1;
  assign bus.m2_stall_o = req[2] & ~gnt2;
  assign bus.m0_data_o  = gnt0 ? bus.s_data_i : ZERO_WORD;
  assign bus.m1_data_o  = gnt1 ? bus.s_data_i : ZERO_WORD;
  assign bus.m2_data_o  = gnt2 ? bus.s_data_i : ZERO_WORD;
  assign bus.gnt_id_o   = busy ? gnt_q : GNT_NONE;
  assign bus.busy_o     = busy;

endmodule
